// File: rtl/seq_alu.sv
// seq_alu: two-operand ALU between the register file and writeback.
// Picks A/B from a flattened register bus, runs one of eight ops and
// registers a 2*WIDTH result with {Z,N,C,V} flags behind a valid/ready
// handshake on both sides. The result is held while the consumer stalls.
// Optional: define SEQ_ALU_MUL_EN to build the shift-add multiplier (op 5)
// and its BUSY state; without it op 5 behaves like the reserved op 7.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  parameter int SEL_W = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREGS*WIDTH-1:0] r_file,
  input  logic [SEL_W-1:0]       sel_a,
  input  logic [SEL_W-1:0]       sel_b,
  input  logic [2:0]             op,
  input  logic                   sig,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_lo,
  output logic [WIDTH-1:0]       out_hi,
  output logic [3:0]             flags
);

  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1
`ifdef SEQ_ALU_MUL_EN
    , BUSY = 2'd2
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [3:0]       flags_q, flags_d;

  // Unpacked view of the register bus so operand selects are simple indexes
  logic [WIDTH-1:0] regs [NREGS];
  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    assign regs[g] = r_file[g*WIDTH +: WIDTH];
  end

  logic [WIDTH-1:0] a, b;
  assign a = regs[sel_a];
  assign b = regs[sel_b];

  logic accept;
  // in_ready looks at out_ready combinationally so a draining result can be
  // replaced by a new one on the same edge (full throughput).
  assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign out_lo    = lo_q;
  assign out_hi    = hi_q;
  assign flags     = flags_q;

  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] res_lo;
  logic             res_c, res_v, res_rsv, lt;
  logic [3:0]       res_flags;

  // Single-cycle datapath: result and flags for everything except MUL
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    dif     = {1'b0, a} - {1'b0, b};
    lt      = sig ? ($signed(a) < $signed(b)) : (a < b);
    res_lo  = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_rsv = 1'b0;
    case (op)
      OP_ADD: begin
        res_lo = sum[MSB:0];
        res_c  = sum[WIDTH];
        res_v  = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res_lo = dif[MSB:0];
        res_c  = dif[WIDTH];
        res_v  = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
      end
      OP_AND:  res_lo = a & b;
      OP_OR:   res_lo = a | b;
      OP_XOR:  res_lo = a ^ b;
      OP_SLT:  res_lo = WIDTH'(lt);
      default: res_rsv = 1'b1;
    endcase
    res_flags = res_rsv ? 4'b1000 : {res_lo == '0, res_lo[MSB], res_c, res_v};
  end

`ifdef SEQ_ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam int         CNT_W  = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, prod;
  logic [WIDTH-1:0]   mplier_q, mplier_d, a_mag, b_mag;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;

  // Magnitudes are WIDTH-bit unsigned, so |MIN| = 2^(WIDTH-1) fits and
  // MIN*MIN comes out right without a special case.
  assign a_mag = (sig && a[MSB]) ? -a : a;
  assign b_mag = (sig && b[MSB]) ? -b : b;
  assign prod  = neg_q ? -acc_q : acc_q;
`endif

  // Next-state and output-register logic
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    flags_d = flags_q;
`ifdef SEQ_ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
`ifdef SEQ_ALU_MUL_EN
          if (op == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
            neg_d    = sig && (a[MSB] ^ b[MSB]);
            state_d  = BUSY;
          end else
`endif
          begin
            lo_d    = res_lo;
            hi_d    = '0;
            flags_d = res_flags;
            state_d = HOLD;
          end
        end else if ((state_q == HOLD) && out_ready) begin
          state_d = IDLE;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      BUSY: begin
        if (cnt_q != '0) begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CNT_W'(1);
        end else begin
          // Sign-fix edge: apply the recorded sign and present the product
          lo_d    = prod[MSB:0];
          hi_d    = prod[2*WIDTH-1:WIDTH];
          flags_d = {prod == '0, prod[2*WIDTH-1], 2'b00};
          state_d = HOLD;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset also discards any partial product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
`ifdef SEQ_ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
`ifdef SEQ_ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
`endif
    end
  end

endmodule
